// File: rtl/input_pixel_queue_pkg.sv
// Shared globals for the input layer and the Layer 1 pixel queue interface.
package input_pixel_queue_pkg;

   localparam int unsigned INPUT_PIXELS = 784;
   localparam int unsigned PIXEL_ADDR_W = 10;

endpackage

// File: rtl/input_pixel_queue_pixel_index_fifo.sv
// Show-ahead circular FIFO of pixel indices; head entry is visible without a pop.
module pixel_index_fifo #(
   parameter int unsigned DEPTH  = 784,
   parameter int unsigned ADDR_W = 10,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [ADDR_W-1:0] pushData,
   input  logic              pop,
   output logic [ADDR_W-1:0] popData,
   output logic              empty,
   output logic              full,
   output logic [CNT_W-1:0]  count
);

   logic [ADDR_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              empty_q;
   logic              do_push, do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= (count_d == '0);
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_q] <= pushData;
      end
   end

   assign popData = mem[rd_ptr_q];
   assign empty   = empty_q;
   assign count   = count_q;

endmodule

// File: rtl/input_pixel_queue.sv
// Captures a binary image, scans it into the pixel index FIFO, then exposes the
// complete queue to Layer 1 until it has been drained.
module input_pixel_queue
   import input_pixel_queue_pkg::*;
#(
   parameter int unsigned PIXELS = INPUT_PIXELS,
   parameter int unsigned ADDR_W = PIXEL_ADDR_W,
   parameter int unsigned DEPTH  = INPUT_PIXELS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [PIXELS-1:0] imageIn,
   input  logic              imageValid,
   output logic              imageAccepted,
   input  logic              dequeue,
   output logic [ADDR_W-1:0] queueOut,
   output logic              queueEmpty,
   output logic              inputsReady,
   output logic              imageDone
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      StIdle,
      StScan,
      StReady
   } state_e;

   state_e            state_q, state_d;
   logic [PIXELS-1:0] image_q;
   logic              image_load;
   logic [ADDR_W-1:0] scan_idx_q, scan_idx_d;
   logic              accepted_q, accepted_d;
   logic              done_q, done_d;

   logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
   logic [ADDR_W-1:0] fifo_data;
   logic [CNT_W-1:0]  fifo_count;

   always_comb begin
      state_d    = state_q;
      scan_idx_d = scan_idx_q;
      image_load = 1'b0;
      fifo_push  = 1'b0;
      fifo_pop   = 1'b0;
      accepted_d = 1'b0;
      done_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (imageValid) begin
               image_load = 1'b1;
               accepted_d = 1'b1;
               scan_idx_d = '0;
               state_d    = StScan;
            end
         end
         StScan: begin
            fifo_push  = image_q[scan_idx_q];
            scan_idx_d = scan_idx_q + ADDR_W'(1);
            if (scan_idx_q == ADDR_W'(PIXELS - 1)) begin
               scan_idx_d = '0;
               // The final push lands on this same edge, so count it here.
               if (fifo_count != '0 || fifo_push) begin
                  state_d = StReady;
               end else begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end
         end
         StReady: begin
            fifo_pop = dequeue && !fifo_empty;
            if (fifo_pop && fifo_count == CNT_W'(1)) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         scan_idx_q <= '0;
         accepted_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         scan_idx_q <= scan_idx_d;
         accepted_q <= accepted_d;
         done_q     <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         image_q <= '0;
      end else if (image_load) begin
         image_q <= imageIn;
      end
   end

   pixel_index_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (fifo_push),
      .pushData (scan_idx_q),
      .pop      (fifo_pop),
      .popData  (fifo_data),
      .empty    (fifo_empty),
      .full     (fifo_full),
      .count    (fifo_count)
   );

   // DEPTH >= PIXELS makes this unreachable; the FIFO drops such a push.
   a_no_full_push : assert property (@(posedge clk) disable iff (reset)
      !(fifo_push && fifo_full));

   assign imageAccepted = accepted_q;
   assign imageDone     = done_q;
   assign inputsReady   = (state_q == StReady);
   assign queueEmpty    = fifo_empty;
   assign queueOut      = fifo_empty ? '0 : fifo_data;

endmodule

// File: tb/tb_input_pixel_queue.sv
// Randomized bench for input_pixel_queue against a queue-of-set-indices model.
module tb_input_pixel_queue;

   localparam int unsigned PIX = 784;
   localparam int unsigned AW  = 10;

   logic           clk = 1'b0;
   logic           reset;
   logic [PIX-1:0] imageIn;
   logic           imageValid;
   logic           imageAccepted;
   logic           dequeue;
   logic [AW-1:0]  queueOut;
   logic           queueEmpty;
   logic           inputsReady;
   logic           imageDone;

   int total = 0;
   int bad   = 0;
   logic [AW-1:0] exp_q[$];

   input_pixel_queue #(
      .PIXELS (PIX),
      .ADDR_W (AW),
      .DEPTH  (PIX)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .imageIn       (imageIn),
      .imageValid    (imageValid),
      .imageAccepted (imageAccepted),
      .dequeue       (dequeue),
      .queueOut      (queueOut),
      .queueEmpty    (queueEmpty),
      .inputsReady   (inputsReady),
      .imageDone     (imageDone)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [PIX-1:0] rand_image(input int unsigned pct);
      logic [PIX-1:0] img;
      for (int i = 0; i < PIX; i++) img[i] = ($urandom_range(99) < pct);
      return img;
   endfunction

   // Offer an image, then follow the scan until the queue is exposed or the image ends.
   task automatic scan_image(input logic [PIX-1:0] img);
      int n = 0;
      int extra_acc = 0;
      int early_ready = 0;
      int nonempty = 0;
      exp_q.delete();
      for (int i = 0; i < PIX; i++) if (img[i]) exp_q.push_back(AW'(i));
      imageIn    = img;
      imageValid = 1'b1;
      tick();
      total++;
      if (imageAccepted !== 1'b1) begin
         bad++;
         $display("FAIL accept: imageAccepted=%b want 1", imageAccepted);
      end
      imageValid = 1'b0;
      imageIn    = rand_image(50);
      while (inputsReady !== 1'b1 && imageDone !== 1'b1 && n < 2000) begin
         tick();
         n++;
         if (imageAccepted !== 1'b0) extra_acc++;
         if (exp_q.size() == 0 && queueEmpty !== 1'b1) nonempty++;
         if (n < PIX && inputsReady !== 1'b0) early_ready++;
      end
      total++;
      if (n != PIX || extra_acc != 0 || early_ready != 0 || nonempty != 0) begin
         bad++;
         $display("FAIL scan_latency: cycles=%0d extra_acc=%0d early=%0d nonempty=%0d want %0d/0/0/0",
                  n, extra_acc, early_ready, nonempty, PIX);
      end
      total++;
      if (exp_q.size() == 0) begin
         if (imageDone !== 1'b1 || inputsReady !== 1'b0 || queueEmpty !== 1'b1) begin
            bad++;
            $display("FAIL blank_end: done=%b ready=%b empty=%b want 1/0/1",
                     imageDone, inputsReady, queueEmpty);
         end
      end else if (inputsReady !== 1'b1 || imageDone !== 1'b0 || queueEmpty !== 1'b0
                   || queueOut !== exp_q[0]) begin
         bad++;
         $display("FAIL ready_head: ready=%b done=%b empty=%b head=%0d want 1/0/0/%0d",
                  inputsReady, imageDone, queueEmpty, queueOut, exp_q[0]);
      end
   endtask

   // Drain with a random dequeue pattern; stall_pct is the chance dequeue is low.
   task automatic drain(input int unsigned stall_pct);
      int guard = 0;
      logic exp_done;
      while (exp_q.size() > 0 && guard < 20000) begin
         dequeue = ($urandom_range(99) >= stall_pct);
         total++;
         if (queueOut !== exp_q[0]) begin
            bad++;
            $display("FAIL drain_data: queueOut=%0d want %0d", queueOut, exp_q[0]);
         end
         tick();
         guard++;
         if (dequeue) void'(exp_q.pop_front());
         exp_done = dequeue && exp_q.size() == 0;
         total++;
         if (imageDone !== exp_done || inputsReady !== (exp_q.size() != 0)) begin
            bad++;
            $display("FAIL drain_flags: done=%b ready=%b want %b/%b",
                     imageDone, inputsReady, exp_done, exp_q.size() != 0);
         end
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain_timeout: left=%0d want 0", exp_q.size());
      end
      // Keep popping an empty queue: nothing may change.
      dequeue = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (imageDone !== 1'b0 || queueEmpty !== 1'b1 || inputsReady !== 1'b0) begin
            bad++;
            $display("FAIL post_drain: done=%b empty=%b ready=%b want 0/1/0",
                     imageDone, queueEmpty, inputsReady);
         end
      end
      dequeue = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      total++;
      if (imageAccepted !== 1'b0 || inputsReady !== 1'b0 || imageDone !== 1'b0
          || queueEmpty !== 1'b1 || queueOut !== '0) begin
         bad++;
         $display("FAIL %s: acc=%b ready=%b done=%b empty=%b out=%0d want 0/0/0/1/0",
                  tag, imageAccepted, inputsReady, imageDone, queueEmpty, queueOut);
      end
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      imageValid = 1'b0;
      imageIn    = '0;
      dequeue    = 1'b0;
      tick();
      tick();
      check_reset_vals("reset");
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         dequeue = i[0];
         tick();
         check_reset_vals("idle_dequeue");
      end
      dequeue = 1'b0;
   endtask

   task automatic test_sparse();
      logic [PIX-1:0] img = '0;
      img[0]   = 1'b1;
      img[5]   = 1'b1;
      img[783] = 1'b1;
      scan_image(img);
      drain(0);
   endtask

   task automatic test_blank();
      scan_image('0);
      tick();
      total++;
      if (imageDone !== 1'b0 || queueEmpty !== 1'b1) begin
         bad++;
         $display("FAIL blank_pulse: done=%b empty=%b want 0/1", imageDone, queueEmpty);
      end
   endtask

   task automatic test_full();
      logic [PIX-1:0] img = '0;
      scan_image('1);
      drain(0);
      img[2] = 1'b1;
      scan_image(img);
      drain(0);
   endtask

   task automatic test_stall();
      logic [PIX-1:0] img = '0;
      img[10] = 1'b1;
      img[20] = 1'b1;
      scan_image(img);
      for (int i = 0; i < 50; i++) begin
         tick();
         total++;
         if (queueOut !== AW'(10) || inputsReady !== 1'b1) begin
            bad++;
            $display("FAIL stall: queueOut=%0d ready=%b want 10/1", queueOut, inputsReady);
         end
      end
      drain(0);
      img    = '0;
      img[7] = 1'b1;
      scan_image(img);
      drain(0);
   endtask

   task automatic test_random();
      for (int k = 0; k < 3; k++) begin
         scan_image(rand_image(3 + 10 * k));
         drain(30);
      end
   endtask

   task automatic test_reset_mid();
      logic [PIX-1:0] img;
      scan_image_abort();
      img = rand_image(5);
      img[100] = 1'b1;
      img[200] = 1'b1;
      scan_image(img);
      dequeue = 1'b1;
      tick();
      dequeue = 1'b0;
      reset   = 1'b1;
      tick();
      check_reset_vals("reset_ready");
      reset = 1'b0;
      scan_image(rand_image(8));
      drain(20);
   endtask

   task automatic scan_image_abort();
      imageIn    = rand_image(20);
      imageValid = 1'b1;
      tick();
      imageValid = 1'b0;
      for (int i = 0; i < 400; i++) tick();
      reset = 1'b1;
      tick();
      check_reset_vals("reset_scan");
      reset = 1'b0;
      scan_image(rand_image(10));
      drain(10);
   endtask

   initial begin
      test_reset();
      test_sparse();
      test_blank();
      test_full();
      test_stall();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
